// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC pre-rotation front end.
package cordic_pkg;

  typedef enum logic [1:0] {
    Q0   = 2'd0,
    Q90  = 2'd1,
    Q180 = 2'd2,
    Q270 = 2'd3
  } quad_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_QUAD   = 2'd2,
    ST_OUT    = 2'd3
  } state_e;

  localparam int DEG360 = 360;
  localparam int DEG90  = 90;

  // Largest shift of 360 that still fits in an ang_w-bit unsigned angle.
  function automatic int kmax(input int ang_w);
    return ang_w - 9;
  endfunction

endpackage

// File: rtl/mod360_reducer.sv
// Multi-cycle modulo-360 reducer: greedy shift-subtract of 360<<k, with k
// stepping from KMAX down to 0, one step per cycle.
module mod360_reducer
  import cordic_pkg::*;
#(
  parameter int ANG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ANG_W-1:0] angle,
  output logic             done,
  output logic [ANG_W-1:0] residue
);

  localparam int KMAX = kmax(ANG_W);
  localparam int KW   = (KMAX < 1) ? 1 : $clog2(KMAX + 1);

  logic             busy;
  logic [KW-1:0]    k;
  logic [ANG_W-1:0] r;
  logic [ANG_W-1:0] thr;

  // 360<<KMAX fits in ANG_W bits, so the shifted threshold never truncates.
  assign thr     = ANG_W'(DEG360) << k;
  // done is high during the k=0 step; the parent leaves REDUCE on that edge.
  assign done    = busy && (k == '0);
  assign residue = r;

  // Step counter and busy flag; an abort via rst_n discards the work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      k    <= '0;
    end else if (start) begin
      busy <= 1'b1;
      k    <= KW'(KMAX);
    end else if (busy) begin
      if (k == '0) begin
        busy <= 1'b0;
      end else begin
        k <= k - 1'b1;
      end
    end
  end

  // Residue register: load the raw angle, then conditionally subtract.
  always_ff @(posedge clk) begin
    if (start) begin
      r <= angle;
    end else if (busy && (r >= thr)) begin
      r <= r - thr;
    end
  end

endmodule

// File: rtl/cordic_prerot.sv
// CORDIC front end: handshaked pre-rotation. Rotation mode reduces the angle
// modulo 360 into a 0..89 residue plus quadrant tag; vectoring mode folds
// left-half-plane vectors into the right half-plane.
module cordic_prerot
  import cordic_pkg::*;
#(
  parameter int ANG_W    = 16,
  parameter int DATA_W   = 24,
  parameter int SEL_W    = 4,
  parameter int MODE_BIT = 3,
  parameter int X_INIT   = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic        [ANG_W-1:0]  in_angle,
  input  logic        [ANG_W-1:0]  another,
  input  logic        [SEL_W-1:0]  select,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] y,
  output logic signed [DATA_W-1:0] z,
  output logic        [1:0]        quad,
  output logic                     neg_flag,
  output logic        [SEL_W-1:0]  select_out
);

  localparam logic [ANG_W-1:0] A90  = ANG_W'(DEG90);
  localparam logic [ANG_W-1:0] A180 = ANG_W'(2 * DEG90);
  localparam logic [ANG_W-1:0] A270 = ANG_W'(3 * DEG90);

  state_e                     state;
  quad_e                      quad_q;
  logic        [ANG_W-1:0]    a_q;
  logic        [ANG_W-1:0]    b_q;
  logic        [SEL_W-1:0]    sel_q;
  logic                       red_start;
  logic                       red_done;
  logic        [ANG_W-1:0]    r;
  logic signed [DATA_W-1:0]   ax;
  logic signed [DATA_W-1:0]   ay;
  logic signed [DATA_W-1:0]   x_n;
  logic signed [DATA_W-1:0]   y_n;
  logic signed [DATA_W-1:0]   z_n;
  quad_e                      quad_n;
  logic                       neg_n;

  function automatic logic signed [DATA_W-1:0] sext(input logic [ANG_W-1:0] v);
    return {{(DATA_W-ANG_W){v[ANG_W-1]}}, v};
  endfunction

  function automatic logic signed [DATA_W-1:0] zext(input logic [ANG_W-1:0] v);
    return {{(DATA_W-ANG_W){1'b0}}, v};
  endfunction

  assign in_ready  = (state == ST_IDLE);
  assign red_start = (state == ST_IDLE) && in_valid;
  assign quad      = quad_q;

  mod360_reducer #(
    .ANG_W (ANG_W)
  ) u_red (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (red_start),
    .angle   (in_angle),
    .done    (red_done),
    .residue (r)
  );

  // Operand capture on the accepting edge; vectoring needs them in QUAD.
  always_ff @(posedge clk) begin
    if (red_start) begin
      a_q   <= in_angle;
      b_q   <= another;
      sel_q <= select;
    end
  end

  // QUAD-step results: quadrant fold (rotation) or half-plane fold (vectoring).
  // Negation happens after sign extension so the most negative x has room.
  always_comb begin
    ax     = sext(a_q);
    ay     = sext(b_q);
    x_n    = '0;
    y_n    = '0;
    z_n    = '0;
    quad_n = Q0;
    neg_n  = 1'b0;
    if (sel_q[MODE_BIT]) begin
      if (ax[DATA_W-1]) begin
        x_n    = -ax;
        y_n    = -ay;
        quad_n = Q180;
        neg_n  = 1'b1;
      end else begin
        x_n = ax;
        y_n = ay;
      end
    end else begin
      x_n = DATA_W'(X_INIT);
      if (r >= A270) begin
        quad_n = Q270;
        z_n    = zext(r - A270);
      end else if (r >= A180) begin
        quad_n = Q180;
        z_n    = zext(r - A180);
      end else if (r >= A90) begin
        quad_n = Q90;
        z_n    = zext(r - A90);
      end else begin
        z_n = zext(r);
      end
    end
  end

  // Control FSM with registered outputs, held stable through OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      x          <= '0;
      y          <= '0;
      z          <= '0;
      quad_q     <= Q0;
      neg_flag   <= 1'b0;
      select_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) state <= ST_REDUCE;
        end
        ST_REDUCE: begin
          if (red_done) state <= ST_QUAD;
        end
        ST_QUAD: begin
          x          <= x_n;
          y          <= y_n;
          z          <= z_n;
          quad_q     <= quad_n;
          neg_flag   <= neg_n;
          select_out <= sel_q;
          out_valid  <= 1'b1;
          state      <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
